// File: rtl/life_grid_scan.sv
// Game-of-life board engine: scans the visible board cell by cell, one cell per cycle, through an external rule cell.
// Define LIFE_TORUS_EN for a toroidal board; by default, neighbours off the edge read as 0.
module life_grid_scan #(
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [$clog2(ROWS*COLS)-1:0]  load_addr,
    input  logic                          load_data,
    input  logic                          start,
    input  logic [7:0]                    gens,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   gen_count,
    output logic                          cell_valid,
    output logic                          cell_self,
    output logic [7:0]                    cell_n,
    input  logic                          cell_next,
    input  logic [$clog2(ROWS*COLS)-1:0]  rd_addr,
    output logic                          rd_data
);
    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [AW:0]   N_EXT    = (AW+1)'(N);
    localparam logic [AW-1:0] LAST     = AW'(N - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, FIN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  cur, nxt;
    logic [AW-1:0] idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [7:0]    remaining;
    logic          load_ok;

    // Neighbour window in NW,N,NE,W,E,SW,S,SE order; row/col counters avoid dividing idx.
    function automatic logic [7:0] window(input logic [N-1:0] b, input int r, input int c);
        logic [7:0] w;
        int dr, dc, nr, nc;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0, 1, 2: dr = -1;
                3, 4:    dr = 0;
                default: dr = 1;
            endcase
            case (k)
                0, 3, 5: dc = -1;
                1, 6:    dc = 0;
                default: dc = 1;
            endcase
            nr = r + dr;
            nc = c + dc;
`ifdef LIFE_TORUS_EN
            nr = (nr + ROWS) % ROWS;
            nc = (nc + COLS) % COLS;
            w[3'(k)] = b[AW'(nr * COLS + nc)];
`else
            if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
                w[3'(k)] = b[AW'(nr * COLS + nc)];
`endif
        end
        return w;
    endfunction

    assign load_ok = ({1'b0, load_addr} < N_EXT);
    assign rd_data = ({1'b0, rd_addr} < N_EXT) ? cur[rd_addr] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        done       = 1'b0;
        cell_valid = 1'b0;
        cell_self  = 1'b0;
        cell_n     = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = (gens != 8'd0) ? SCAN : FIN;
            end
            SCAN: begin
                cell_valid = 1'b1;
                cell_self  = cur[idx];
                cell_n     = window(cur, int'(row), int'(col));
                if (idx == LAST) state_d = COMMIT;
            end
            COMMIT: state_d = (remaining == 8'd1) ? FIN : SCAN;
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // cur stays frozen while scanning; nxt collects results until the commit swaps them in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            nxt       <= '0;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
            remaining <= '0;
            gen_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en && load_ok) cur[load_addr] <= load_data;
                    if (start && gens != 8'd0) begin
                        remaining <= gens;
                        idx       <= '0;
                        row       <= '0;
                        col       <= '0;
                    end
                end
                SCAN: begin
                    nxt[idx] <= cell_next;
                    if (idx == LAST) begin
                        idx <= '0;
                        row <= '0;
                        col <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    cur       <= nxt;
                    gen_count <= gen_count + 16'd1;
                    remaining <= remaining - 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_life_grid_scan.sv
// Randomized bench for life_grid_scan against a 2-D life model; honours LIFE_TORUS_EN like the design.
module tb_life_grid_scan;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;
    localparam int AW   = 6;

    logic          clk, rst_n, load_en, load_data, start;
    logic [AW-1:0] load_addr, rd_addr;
    logic [7:0]    gens;
    logic          busy, done, cell_valid, cell_self, cell_next, rd_data;
    logic [15:0]   gen_count;
    logic [7:0]    cell_n;

    int            checks = 0;
    int            errors = 0;
    int            exp_gc = 0;
    logic [N-1:0]  mboard = '0;

    life_grid_scan #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .gens(gens), .busy(busy), .done(done),
        .gen_count(gen_count), .cell_valid(cell_valid), .cell_self(cell_self),
        .cell_n(cell_n), .cell_next(cell_next), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // External rule cell: standard B3/S23.
    assign cell_next = ($countones(cell_n) == 3) || (cell_self && $countones(cell_n) == 2);

    always #5 clk = ~clk;

    function automatic bit mcell(input logic [N-1:0] b, input int r, input int c);
`ifdef LIFE_TORUS_EN
        r = (r + ROWS) % ROWS;
        c = (c + COLS) % COLS;
`else
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
`endif
        return b[AW'(r * COLS + c)];
    endfunction

    function automatic logic [7:0] mwindow(input logic [N-1:0] b, input int r, input int c);
        logic [7:0] w = '0;
        int k = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) begin
                    w[3'(k)] = mcell(b, r + dr, c + dc);
                    k++;
                end
        return w;
    endfunction

    function automatic logic [N-1:0] mstep(input logic [N-1:0] b);
        logic [N-1:0] nb = '0;
        int cnt;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && mcell(b, r + dr, c + dc)) cnt++;
                nb[AW'(r * COLS + c)] = (cnt == 3) || (mcell(b, r, c) && cnt == 2);
            end
        return nb;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic loadBoard(input logic [N-1:0] b);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = b[AW'(i)];
        end
        @(negedge clk);
        load_en = 1'b0;
        mboard  = b;
    endtask

    task automatic readBoard(output logic [N-1:0] b);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            b[AW'(i)] = rd_data;
        end
    endtask

    // One run of g generations; noise drives start/load inputs randomly while busy.
    task automatic applyStimulus(input int g, input bit noise, input bit wr, input int waddr, input bit wdata);
        logic [N-1:0] gb[$];
        logic [N-1:0] b, rb;
        int n, v, errs, limit, k, p;
        bit seen;
        if (wr) mboard[AW'(waddr)] = wdata;
        gb.push_back(mboard);
        for (int i = 0; i < g; i++) gb.push_back(mstep(gb[i]));
        @(negedge clk);
        start     = 1'b1;
        gens      = 8'(g);
        load_en   = wr;
        load_addr = AW'(waddr);
        load_data = wdata;
        n = 0; v = 0; errs = 0; seen = 0;
        limit = g * (N + 1) + 10;
        while (!seen && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (noise) begin
                start     = 1'($urandom);
                gens      = 8'($urandom);
                load_en   = 1'($urandom);
                load_addr = AW'($urandom);
                load_data = 1'($urandom);
            end else begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            if (cell_valid) begin
                k = v / N;
                p = v % N;
                if (k >= g) errs++;
                else begin
                    b = gb[k];
                    if (cell_self !== b[AW'(p)] || cell_n !== mwindow(b, p / COLS, p % COLS)) errs++;
                end
                v++;
            end
            if (done) seen = 1'b1;
        end
        start   = 1'b0;
        load_en = 1'b0;
        checkOutput("done_seen", 64'(seen), 64'(1));
        checkOutput("latency", 64'(n), 64'(g * (N + 1) + 1));
        checkOutput("valid_cycles", 64'(v), 64'(g * N));
        checkOutput("window", 64'(errs), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("done_pulse", 64'(done), 64'(0));
        checkOutput("busy_idle", 64'(busy), 64'(0));
        checkOutput("window_idle", 64'({cell_valid, cell_self, cell_n}), 64'(0));
        mboard = gb[g];
        exp_gc += g;
        checkOutput("gen_count", 64'(gen_count), 64'(16'(exp_gc)));
        readBoard(rb);
        checkOutput("board", rb, mboard);
    endtask

    initial begin
        logic [N-1:0] rb, blinker, vert, block, glider;
        bit saw_done;
        clk = 0; rst_n = 1; load_en = 0; load_addr = '0; load_data = 0;
        start = 0; gens = '0; rd_addr = '0;
        blinker = '0; blinker[26] = 1; blinker[27] = 1; blinker[28] = 1;
        vert    = '0; vert[19] = 1; vert[27] = 1; vert[35] = 1;
        block   = '0; block[0] = 1; block[1] = 1; block[8] = 1; block[9] = 1;
        glider  = '0; glider[1] = 1; glider[10] = 1; glider[16] = 1; glider[17] = 1; glider[18] = 1;

        #3 rst_n = 0;
        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_window", 64'({cell_valid, cell_self, cell_n}), 64'(0));
        checkOutput("rst_gen_count", 64'(gen_count), 64'(0));
        readBoard(rb);
        checkOutput("rst_board", rb, 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;

        loadBoard(blinker);
        applyStimulus(1, 0, 0, 0, 0);
        readBoard(rb);
        checkOutput("blinker_vertical", rb, vert);

        loadBoard(block);
        applyStimulus(10, 1, 0, 0, 0);
        readBoard(rb);
        checkOutput("block_still", rb, block);

        applyStimulus(0, 1, 0, 0, 0);

`ifdef LIFE_TORUS_EN
        block = '0; block[63] = 1; block[56] = 1; block[7] = 1; block[0] = 1;
        loadBoard(block);
        applyStimulus(10, 0, 0, 0, 0);
        readBoard(rb);
        checkOutput("corner_block", rb, block);
`endif

        loadBoard(glider);
        applyStimulus(32, 1, 0, 0, 0);
`ifdef LIFE_TORUS_EN
        readBoard(rb);
        checkOutput("glider_wrap", rb, glider);
`endif

        loadBoard({$urandom, $urandom});
        applyStimulus(2, 0, 1, $urandom_range(0, N - 1), 1'b1);

        for (int t = 0; t < 6; t++) begin
            loadBoard({$urandom, $urandom});
            applyStimulus($urandom_range(1, 4), 1, 0, 0, 0);
        end

        loadBoard({$urandom, $urandom} | blinker);
        @(negedge clk);
        start = 1; gens = 8'd3;
        @(posedge clk);
        #1;
        start = 0;
        saw_done = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        checkOutput("mid_run_valid", 64'(cell_valid), 64'(1));
        #2 rst_n = 0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_window", 64'({cell_valid, cell_self, cell_n}), 64'(0));
        checkOutput("abort_gen_count", 64'(gen_count), 64'(0));
        readBoard(rb);
        checkOutput("abort_board", rb, 64'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        @(negedge clk);
        rst_n = 1;
        checkOutput("abort_no_done", 64'(saw_done), 64'(0));
        mboard = '0;
        exp_gc = 0;

        loadBoard(glider);
        applyStimulus(4, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/life_grid_scan.md
LIFE_GRID_SCAN -- requirements
Module: life_grid_scan

Interface
REQ-001 Parameter COLS, default 8: board width in cells, 2..32.
REQ-002 Parameter ROWS, default 8: board height in cells, 2..32.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port load_en, input, 1: write one cell of the current board.
REQ-006 Port load_addr, input, clog2(ROWS*COLS): cell index, row*COLS+col.
REQ-007 Port load_data, input, 1: cell value to write.
REQ-008 Port start, input, 1: begin a run of gens generations.
REQ-009 Port gens, input, 8: generation count, sampled on an accepted start.
REQ-010 Port busy, output, 1: run in progress.
REQ-011 Port done, output, 1: one-cycle pulse at end of run.
REQ-012 Port gen_count, output, 16: generations completed since reset, wrapping.
REQ-013 Port cell_valid, output, 1: window on cell_self/cell_n is being evaluated.
REQ-014 Port cell_self, output, 1: current value of cell idx.
REQ-015 Port cell_n, output, 8: neighbours of idx, bit0..7 = NW,N,NE,W,E,SW,S,SE.
REQ-016 Port cell_next, input, 1: next state from external combinational rule cell, same cycle.
REQ-017 Port rd_addr, input, clog2(ROWS*COLS): readout index.
REQ-018 Port rd_data, output, 1: combinational current-board value at rd_addr.

Function
REQ-019 Block SHALL hold two ROWS*COLS bit boards: cur (visible) and nxt (shadow).
REQ-020 FSM states SHALL be IDLE, SCAN, COMMIT, FIN.
REQ-021 IDLE: load_en SHALL write load_data into cur[load_addr]; load_en ignored in every other state.
REQ-022 IDLE with start=1 and gens!=0: latch gens into remaining, idx=0, go SCAN next cycle.
REQ-023 IDLE with start=1 and gens==0: go FIN directly; boards and gen_count unchanged.
REQ-024 Same-cycle load_en and start in IDLE: write applied, first SCAN cycle sees it.
REQ-025 SCAN: cell_valid=1; window drawn from cur at idx; cell_next written to nxt[idx]; idx increments each cycle.
REQ-026 SCAN at idx=ROWS*COLS-1: go COMMIT.
REQ-027 COMMIT: cur<=nxt in one cycle; gen_count+1; remaining-1; if remaining becomes 0 go FIN, else idx=0 and SCAN.
REQ-028 FIN: done=1 for exactly one cycle, then IDLE.
REQ-029 Latency per generation: ROWS*COLS+1 cycles; run of g generations: g*(ROWS*COLS+1)+1 cycles from start to done.
REQ-030 busy SHALL be 1 in SCAN, COMMIT and FIN; 0 in IDLE; start while busy SHALL be ignored.
REQ-031 cell_valid, cell_self and cell_n SHALL be 0 outside SCAN.
REQ-032 cur SHALL not change during SCAN; rd_data reflects previous generation until COMMIT.
REQ-033 load_addr or rd_addr >= ROWS*COLS: write dropped, rd_data=0.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, cur=0, nxt=0, idx=0, remaining=0, gen_count=0, busy=0, done=0, cell_valid=0.
REQ-035 Reset mid-run SHALL abort without a done pulse; partial nxt contents discarded.

Configuration
REQ-036 Macro LIFE_TORUS_EN defined: neighbour rows/columns wrap modulo ROWS/COLS (toroidal board).
REQ-037 LIFE_TORUS_EN undefined: neighbours outside the board SHALL read as 0; interface and timing unchanged.

Verification
REQ-038 8x8, horizontal blinker at (3,2..4), gens=1 -> vertical blinker at (2..4,3), done 66 cycles after start, gen_count=1.
REQ-039 Block still life at (0..1,0..1), gens=10 -> board unchanged, gen_count=10; with LIFE_TORUS_EN, block at (7..0,7..0) corner also still.
REQ-040 Glider, LIFE_TORUS_EN, gens=32 -> glider returns to start pattern (8-cycle wrap x4); without macro it settles into a block at the edge.
REQ-041 start with gens=0 -> done 1 cycle later, board and gen_count unchanged; load_en during busy -> cur unaffected.
REQ-042 rst_n pulsed low at idx=20 of a run -> busy=0, board all 0, no done, next start runs normally.
